// File: rtl/traffic_pkg.sv
// Shared types and lamp helpers for the traffic light datapath.
// Holds the phase encoding, lamp codes, lane masks and pattern-coercion functions.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } phase_e;

    localparam logic [1:0] LAMP_GREEN  = 2'b11;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b00;

    localparam logic [7:0] NS_MASK = 8'b00110011;
    localparam logic [7:0] EW_MASK = 8'b11001100;

    // Any pair other than 11 is a red request.
    function automatic logic [7:0] coerce_pattern(input logic [7:0] p);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[2*i +: 2] = (p[2*i +: 2] == LAMP_GREEN) ? LAMP_GREEN : LAMP_RED;
        end
        return r;
    endfunction

    function automatic logic [7:0] green_to_yellow(input logic [7:0] p);
        logic [7:0] r;
        r = p;
        for (int unsigned i = 0; i < 4; i++) begin
            if (p[2*i +: 2] == LAMP_GREEN) begin
                r[2*i +: 2] = LAMP_YELLOW;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] green_load(input logic [6:0] t);
        return (t == 7'd0) ? 7'd1 : t;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable 7-bit phase down-counter advanced by the timebase tick.
// expire flags the tick that would take the count from 1 to 0.
module phase_counter #(
    parameter logic [6:0] RESET_VAL = 7'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [6:0] count,
    output logic       expire
);

    logic [6:0] count_q;
    logic [6:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != 7'd0)) begin
            count_d = count_q - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = tick && (count_q == 7'd1);

endmodule

// File: rtl/light_phase_timer.sv
// Lamp sequencer between the pattern generators and the lamp drivers:
// green for the requested duration, then yellow and all-red clearance.
module light_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_TICKS  = 3,
    parameter int unsigned ALL_RED_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] nextLights,
    input  logic [6:0] loadTime,
    output logic [7:0] lampOutput,
    output logic       advance,
    output logic [6:0] phaseRemaining,
    output logic [1:0] phase
);

    localparam logic [6:0] YELLOW_LD  = 7'(YELLOW_TICKS);
    localparam logic [6:0] ALL_RED_LD = 7'(ALL_RED_TICKS);

    phase_e     state_q, state_d;
    logic [7:0] lamp_q, lamp_d;
    logic       adv_q, adv_d;
    logic       cnt_load;
    logic [6:0] cnt_load_val;
    logic       expire;
    logic [7:0] next_pat;

    phase_counter #(
        .RESET_VAL(ALL_RED_LD)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .count   (phaseRemaining),
        .expire  (expire)
    );

    assign next_pat = coerce_pattern(nextLights);

    always_comb begin
        state_d      = state_q;
        lamp_d       = lamp_q;
        adv_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_ALL_RED: begin
                if (expire) begin
                    lamp_d       = next_pat;
                    cnt_load     = 1'b1;
                    cnt_load_val = green_load(loadTime);
                    state_d      = ST_GREEN;
                    adv_d        = 1'b1;
                end
            end
            ST_GREEN: begin
                if (expire) begin
                    if (next_pat != lamp_q) begin
                        lamp_d       = green_to_yellow(lamp_q);
                        cnt_load     = 1'b1;
                        cnt_load_val = YELLOW_LD;
                        state_d      = ST_YELLOW;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = green_load(loadTime);
                        // A 1-tick green continuing straight after an advance
                        // withholds this pulse so advance never runs back to back.
                        adv_d        = ~adv_q;
                    end
                end
            end
            ST_YELLOW: begin
                if (expire) begin
                    lamp_d       = '0;
                    cnt_load     = 1'b1;
                    cnt_load_val = ALL_RED_LD;
                    state_d      = ST_ALL_RED;
                end
            end
            default: begin
                lamp_d       = '0;
                cnt_load     = 1'b1;
                cnt_load_val = ALL_RED_LD;
                state_d      = ST_ALL_RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ALL_RED;
            lamp_q  <= '0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp_d;
            adv_q   <= adv_d;
        end
    end

    assign lampOutput = lamp_q;
    assign advance    = adv_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_light_phase_timer.sv
// Directed bench for light_phase_timer with hand-computed lamp sequences.
module tb_light_phase_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] nextLights;
    logic [6:0] loadTime;
    logic [7:0] lampOutput;
    logic       advance;
    logic [6:0] phaseRemaining;
    logic [1:0] phase;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] ALT_SEQ [10] = '{8'hCC, 8'h44, 8'h44, 8'h44, 8'h00,
                                            8'h33, 8'h11, 8'h11, 8'h11, 8'h00};
    localparam logic [7:0] SLOW_LAMP [7] = '{8'hCC, 8'hCC, 8'h44, 8'h44, 8'h44, 8'h00, 8'h33};
    localparam logic [6:0] SLOW_REM  [7] = '{7'd2, 7'd1, 7'd3, 7'd2, 7'd1, 7'd1, 7'd2};
    localparam logic [1:0] SLOW_PH   [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};

    light_phase_timer #(
        .YELLOW_TICKS (3),
        .ALL_RED_TICKS(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .nextLights    (nextLights),
        .loadTime      (loadTime),
        .lampOutput    (lampOutput),
        .advance       (advance),
        .phaseRemaining(phaseRemaining),
        .phase         (phase)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b1; nextLights = 8'hCC; loadTime = 7'd5;
        cycles(2);
        tests++; if (lampOutput !== 8'h00) begin fails++; $display("FAIL reset_lamp got=%h exp=00", lampOutput); end
        tests++; if (phase !== 2'b00) begin fails++; $display("FAIL reset_phase got=%b exp=00", phase); end
        tests++; if (phaseRemaining !== 7'd1) begin fails++; $display("FAIL reset_remaining got=%0d exp=1", phaseRemaining); end
        tests++; if (advance !== 1'b0) begin fails++; $display("FAIL reset_advance got=%b exp=0", advance); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cycles(1);
        tests++; if (lampOutput !== 8'hCC) begin fails++; $display("FAIL basic_green_lamp got=%h exp=cc", lampOutput); end
        tests++; if (advance !== 1'b1) begin fails++; $display("FAIL basic_first_advance got=%b exp=1", advance); end
        tests++; if (phaseRemaining !== 7'd5) begin fails++; $display("FAIL basic_green_load got=%0d exp=5", phaseRemaining); end
        nextLights = 8'h33;
        cycles(1);
        tests++; if (advance !== 1'b0) begin fails++; $display("FAIL basic_advance_once got=%b exp=0", advance); end
        tests++; if (phaseRemaining !== 7'd4) begin fails++; $display("FAIL basic_decrement got=%0d exp=4", phaseRemaining); end
        cycles(4);
        tests++; if (lampOutput !== 8'h44) begin fails++; $display("FAIL basic_yellow_lamp got=%h exp=44", lampOutput); end
        tests++; if (phase !== 2'b10) begin fails++; $display("FAIL basic_yellow_phase got=%b exp=10", phase); end
        tests++; if (phaseRemaining !== 7'd3) begin fails++; $display("FAIL basic_yellow_load got=%0d exp=3", phaseRemaining); end
        cycles(3);
        tests++; if (lampOutput !== 8'h00 || phase !== 2'b00) begin fails++; $display("FAIL basic_allred got=%h/%b exp=00/00", lampOutput, phase); end
        cycles(1);
        tests++; if (lampOutput !== 8'h33 || advance !== 1'b1) begin fails++; $display("FAIL basic_reload got=%h/%b exp=33/1", lampOutput, advance); end
    endtask

    task automatic test_hold();
        nextLights = 8'h33; loadTime = 7'd2;
        cycles(5);
        tests++; if (lampOutput !== 8'h33 || phase !== 2'b01) begin fails++; $display("FAIL hold_lamp got=%h/%b exp=33/01", lampOutput, phase); end
        tests++; if (advance !== 1'b1 || phaseRemaining !== 7'd2) begin fails++; $display("FAIL hold_reload got=%b/%0d exp=1/2", advance, phaseRemaining); end
        cycles(1);
        tests++; if (advance !== 1'b0 || phaseRemaining !== 7'd1) begin fails++; $display("FAIL hold_count got=%b/%0d exp=0/1", advance, phaseRemaining); end
        cycles(1);
        tests++; if (advance !== 1'b1 || lampOutput !== 8'h33) begin fails++; $display("FAIL hold_second got=%b/%h exp=1/33", advance, lampOutput); end
    endtask

    task automatic test_alternate();
        int n_adv;
        n_adv = 0;
        tick = 1'b1; nextLights = 8'hCC; loadTime = 7'd1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            tests++; if (lampOutput !== ALT_SEQ[i % 10]) begin fails++; $display("FAIL alt_lamp[%0d] got=%h exp=%h", i, lampOutput, ALT_SEQ[i % 10]); end
            tests++; if (advance !== ((i % 5) == 0)) begin fails++; $display("FAIL alt_advance[%0d] got=%b exp=%b", i, advance, ((i % 5) == 0)); end
            if (advance === 1'b1) begin
                n_adv++;
                nextLights = (nextLights == 8'hCC) ? 8'h33 : 8'hCC;
            end
        end
        tests++; if (n_adv != 4) begin fails++; $display("FAIL alt_advance_count got=%0d exp=4", n_adv); end
    endtask

    task automatic test_zero_load();
        tick = 1'b1; nextLights = 8'b10011101; loadTime = 7'd0;
        do_reset();
        cycles(1);
        tests++; if (lampOutput !== 8'b00001100) begin fails++; $display("FAIL zero_coerce got=%b exp=00001100", lampOutput); end
        tests++; if (phaseRemaining !== 7'd1) begin fails++; $display("FAIL zero_load got=%0d exp=1", phaseRemaining); end
        nextLights = 8'h00;
        cycles(1);
        tests++; if (phase !== 2'b10 || lampOutput !== 8'b00000100) begin fails++; $display("FAIL zero_one_tick got=%b/%b exp=10/00000100", phase, lampOutput); end
    endtask

    task automatic test_slow_tick();
        tick = 1'b0; nextLights = 8'hCC; loadTime = 7'd2;
        do_reset();
        for (int g = 0; g < 7; g++) begin
            tick = 1'b1;
            cycles(1);
            tick = 1'b0;
            tests++; if (advance !== (g == 0 || g == 6)) begin fails++; $display("FAIL slow_advance[%0d] got=%b exp=%b", g, advance, (g == 0 || g == 6)); end
            if (g == 0) nextLights = 8'h33;
            cycles(3);
            tests++; if (lampOutput !== SLOW_LAMP[g]) begin fails++; $display("FAIL slow_lamp[%0d] got=%h exp=%h", g, lampOutput, SLOW_LAMP[g]); end
            tests++; if (phaseRemaining !== SLOW_REM[g]) begin fails++; $display("FAIL slow_rem[%0d] got=%0d exp=%0d", g, phaseRemaining, SLOW_REM[g]); end
            tests++; if (phase !== SLOW_PH[g] || advance !== 1'b0) begin fails++; $display("FAIL slow_hold[%0d] got=%b/%b exp=%b/0", g, phase, advance, SLOW_PH[g]); end
        end
    endtask

    task automatic test_rst_mid();
        tick = 1'b1; nextLights = 8'hCC; loadTime = 7'd1;
        do_reset();
        cycles(1);
        nextLights = 8'h33;
        cycles(1);
        tests++; if (phase !== 2'b10 || phaseRemaining !== 7'd3) begin fails++; $display("FAIL rstmid_in_yellow got=%b/%0d exp=10/3", phase, phaseRemaining); end
        #2 rst = 1'b1;
        #1;
        tests++; if (lampOutput !== 8'h00 || phase !== 2'b00) begin fails++; $display("FAIL rstmid_async got=%h/%b exp=00/00", lampOutput, phase); end
        tests++; if (phaseRemaining !== 7'd1 || advance !== 1'b0) begin fails++; $display("FAIL rstmid_counter got=%0d/%b exp=1/0", phaseRemaining, advance); end
        @(negedge clk);
        rst = 1'b0;
        tests++; if (phaseRemaining !== 7'd1 || advance !== 1'b0 || lampOutput !== 8'h00) begin fails++; $display("FAIL rstmid_held got=%0d/%b/%h exp=1/0/00", phaseRemaining, advance, lampOutput); end
        cycles(1);
        tests++; if (advance !== 1'b1 || lampOutput !== 8'h33) begin fails++; $display("FAIL rstmid_first_adv got=%b/%h exp=1/33", advance, lampOutput); end
    endtask

    task automatic test_back_to_back();
        tick = 1'b1; nextLights = 8'hCC; loadTime = 7'd1;
        do_reset();
        cycles(1);
        tests++; if (advance !== 1'b1) begin fails++; $display("FAIL b2b_first got=%b exp=1", advance); end
        cycles(1);
        tests++; if (advance !== 1'b0 || phase !== 2'b01 || lampOutput !== 8'hCC) begin fails++; $display("FAIL b2b_gap got=%b/%b/%h exp=0/01/cc", advance, phase, lampOutput); end
        cycles(1);
        tests++; if (advance !== 1'b1) begin fails++; $display("FAIL b2b_next got=%b exp=1", advance); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_alternate();
        test_zero_load();
        test_slow_tick();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
